// File: rtl/bts_pkg.sv
// Shared types and defaults for the branch target sequencer.
package bts_pkg;

  localparam int unsigned STATE_W              = 2;
  localparam int unsigned NR_OF_BITS_DEFAULT   = 8;
  localparam int unsigned RESET_VECTOR_DEFAULT = 0;
  localparam int unsigned STACK_DEPTH_DEFAULT  = 4;

  // Sequencer phases; encodings are fixed so they can be probed in silicon debug.
  typedef enum logic [STATE_W-1:0] {
    ST_RUN    = 2'd0,
    ST_SELECT = 2'd1,
    ST_LATCH  = 2'd2
  } bts_state_e;

endpackage

// File: rtl/bts_return_stack.sv
// Circular LIFO of return addresses; a push when full overwrites the oldest entry.
module bts_return_stack
  import bts_pkg::*;
#(
  parameter int unsigned Width = NR_OF_BITS_DEFAULT,
  parameter int unsigned Depth = STACK_DEPTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] push_data_i,
  output logic [Width-1:0] top_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = $clog2(Depth);
  localparam int unsigned CNT_W = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] top_idx;

  // ptr_q points at the next free slot; the newest entry sits just below it.
  assign top_idx = ptr_q - PTR_W'(1);
  assign top_c   = mem_q[top_idx];
  assign full_c  = (cnt_q == CNT_W'(Depth));
  assign empty_c = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      mem_q[ptr_q] <= push_data_i;
      ptr_q        <= ptr_q + PTR_W'(1);
      if (!full_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (pop_i && !empty_c) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_target_sequencer.sv
// PC sequencer that fetches taken-branch targets from the branch address register Q bus.
// Define BTS_RETURN_STACK_EN to add the call/return stack.
module branch_target_sequencer
  import bts_pkg::*;
#(
  parameter int unsigned NrOfBits    = NR_OF_BITS_DEFAULT,
  parameter int unsigned ResetVector = RESET_VECTOR_DEFAULT,
  parameter int unsigned StackDepth  = STACK_DEPTH_DEFAULT
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                hold,
  input  logic                branch_req,
  input  logic                branch_cond,
  input  logic                call_req,
  input  logic                ret_req,
  input  logic [NrOfBits-1:0] reg_bus,
  output logic                reg_cs,
  output logic [NrOfBits-1:0] pc,
  output logic                pc_valid,
  output logic                branch_ack,
  output logic                stack_err
);

  localparam logic [NrOfBits-1:0] PC_RESET = NrOfBits'(ResetVector);
  localparam logic [NrOfBits-1:0] PC_ONE   = NrOfBits'(1);

  bts_state_e          state_q, state_d;
  logic [NrOfBits-1:0] pc_q, pc_d;
  logic                cs_q, cs_d;
  logic                valid_q, valid_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                step;
  logic                push_c, pop_c;
  logic [NrOfBits-1:0] stack_top_c;
  logic                stack_full_c, stack_empty_c;

  assign step = ClockEnable & Tick & ~hold;

`ifdef BTS_RETURN_STACK_EN
  localparam bit STACK_EN = 1'b1;

  bts_return_stack #(
    .Width (NrOfBits),
    .Depth (StackDepth)
  ) u_return_stack (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .push_i      (push_c),
    .pop_i       (pop_c),
    .push_data_i (pc_q + PC_ONE),
    .top_c       (stack_top_c),
    .full_c      (stack_full_c),
    .empty_c     (stack_empty_c)
  );
`else
  localparam bit STACK_EN = 1'b0;

  logic unused_stack;
  assign stack_top_c   = '0;
  assign stack_full_c  = 1'b0;
  assign stack_empty_c = 1'b1;
  assign unused_stack  = ^{push_c, pop_c, 32'(StackDepth)};
`endif

  // Next-state logic; the register drives the bus for one full step (SELECT) before LATCH samples it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cs_d    = cs_q;
    valid_d = valid_q;
    ack_d   = 1'b0;
    err_d   = err_q;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    if (step) begin
      case (state_q)
        ST_RUN: begin
          if (branch_req && branch_cond) begin
            cs_d    = 1'b0;
            valid_d = 1'b0;
            state_d = ST_SELECT;
            if (STACK_EN && call_req) begin
              push_c = 1'b1;
              if (stack_full_c) begin
                err_d = 1'b1;
              end
            end
          end else if (branch_req) begin
            pc_d  = pc_q + PC_ONE;
            ack_d = 1'b1;
          end else if (STACK_EN && ret_req) begin
            ack_d = 1'b1;
            if (stack_empty_c) begin
              pc_d  = pc_q + PC_ONE;
              err_d = 1'b1;
            end else begin
              pc_d  = stack_top_c;
              pop_c = 1'b1;
            end
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
        ST_SELECT: begin
          state_d = ST_LATCH;
        end
        ST_LATCH: begin
          pc_d    = reg_bus;
          cs_d    = 1'b1;
          valid_d = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cs_d    = 1'b1;
          valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RUN;
      pc_q    <= PC_RESET;
      cs_q    <= 1'b1;
      valid_q <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cs_q    <= cs_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign reg_cs     = cs_q;
  assign pc         = pc_q;
  assign pc_valid   = valid_q;
  assign branch_ack = ack_q;
  assign stack_err  = err_q;

endmodule
